// File: rtl/fcvt_rr_arbiter_if.sv
// fcvt_rr_arbiter_if: requester/consumer handshake bundle; out_inexact exists only when FCVT_RR_INEXACT_EN is defined
interface fcvt_rr_arbiter_if #(parameter int BUS_WIDTH = 64);
    logic                 in0_valid;
    logic [BUS_WIDTH-1:0] in0_data;
    logic                 in0_ready;
    logic                 in1_valid;
    logic [BUS_WIDTH-1:0] in1_data;
    logic                 in1_ready;
    logic                 out_valid;
    logic [BUS_WIDTH-1:0] out_data;
    logic                 out_id;
    logic                 out_ready;
    logic                 busy;
`ifdef FCVT_RR_INEXACT_EN
    logic                 out_inexact;
`endif
    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_id, busy
`ifdef FCVT_RR_INEXACT_EN
        , input out_inexact
`endif
    );
    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_id, busy
`ifdef FCVT_RR_INEXACT_EN
        , output out_inexact
`endif
    );
endinterface

// File: rtl/fcvt_rr_arbiter.sv
// fcvt_rr_arbiter: two-requester round-robin front end to a 2-stage int-to-float pipeline; FCVT_RR_INEXACT_EN adds out_inexact
module fcvt_rr_arbiter #(
    parameter int BUS_WIDTH = 64
) (
    input logic clk,
    input logic rst,
    fcvt_rr_arbiter_if.slave bus
);
    localparam int MANT = (BUS_WIDTH == 64) ? 52 : 23;
    localparam int EXP  = (BUS_WIDTH == 64) ? 11 : 8;
    localparam int BIAS = (BUS_WIDTH == 64) ? 1023 : 127;
    localparam int PW   = $clog2(BUS_WIDTH);
    localparam int TW   = BUS_WIDTH - 1 - MANT;

    logic                 s1_valid, s1_id, s2_valid, s2_id, rr_ptr;
    logic                 s1_adv, s2_adv, grant0, grant1, sign, unused_bits;
    logic [BUS_WIDTH-1:0] s1_data, s2_data, mag, norm, conv;
    logic [PW-1:0]        lead;
`ifdef FCVT_RR_INEXACT_EN
    logic                 inexact, s2_inexact;
`endif

    assign s2_adv = !s2_valid || bus.out_ready;
    assign s1_adv = !s1_valid || s2_adv;
    // grants are held off while reset is asserted so no operand is ever accepted into a clearing pipe
    assign grant0 = !rst && s1_adv && bus.in0_valid && (!bus.in1_valid || !rr_ptr);
    assign grant1 = !rst && s1_adv && bus.in1_valid && (!bus.in0_valid || rr_ptr);

    // convert the S1 operand: magnitude, leading-one position, normalise, truncate
    always_comb begin
        sign = s1_data[BUS_WIDTH-1];
        mag  = sign ? ~s1_data + BUS_WIDTH'(1) : s1_data;
        lead = '0;
        for (int i = 0; i < BUS_WIDTH; i++) if (mag[i]) lead = PW'(i);
        norm = mag << (PW'(BUS_WIDTH - 1) - lead);
        conv = (mag == '0) ? '0 : {sign, EXP'(lead) + EXP'(BIAS), norm[BUS_WIDTH-2 -: MANT]};
    end

    // the hidden leading one and the truncated tail are not part of the result word
    assign unused_bits = ^{norm[BUS_WIDTH-1], norm[TW-1:0]};
`ifdef FCVT_RR_INEXACT_EN
    assign inexact = |norm[TW-1:0];
`endif

    // pipeline stages and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_id    <= 1'b0;
            s2_data  <= '0;
            rr_ptr   <= 1'b0;
`ifdef FCVT_RR_INEXACT_EN
            s2_inexact <= 1'b0;
`endif
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= conv;
                    s2_id   <= s1_id;
`ifdef FCVT_RR_INEXACT_EN
                    s2_inexact <= inexact;
`endif
                end
            end
            if (s1_adv) begin
                s1_valid <= grant0 || grant1;
                if (grant0 || grant1) begin
                    s1_data <= grant1 ? bus.in1_data : bus.in0_data;
                    s1_id   <= grant1;
                end
            end
            if (grant0 || grant1) rr_ptr <= grant0;
        end
    end

    assign bus.in0_ready = grant0;
    assign bus.in1_ready = grant1;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_id    = s2_id;
    assign bus.busy      = s1_valid || s2_valid;
`ifdef FCVT_RR_INEXACT_EN
    assign bus.out_inexact = s2_inexact;
`endif
endmodule

// File: doc/fcvt_rr_arbiter.md
Name: fcvt_rr_arbiter

Overview:
- Shares one integer-to-floating-point conversion datapath between two requesters, e.g. the integer pipeline and the FPU issue port.
- Round-robin arbitration feeds a 2-stage pipeline:
  - S1: operand register.
  - S2: converted-result register.
- Valid/ready handshakes on both sides; results carry the requester's ID tag so the consumer can route them.

Parameters:
- BUS_WIDTH, 64, operand and result width. 64 = int64→double; 32 = int32→single.
- Derived: MANTISSA_SIZE 52/23, EXPONENT_SIZE 11/8, BIAS 1023/127.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- in0_valid  input  1  requester 0 has an operand
- in0_data  input  BUS_WIDTH  requester 0 two's-complement signed integer
- in0_ready  output  1  requester 0 operand accepted this cycle
- in1_valid  input  1  requester 1 has an operand
- in1_data  input  BUS_WIDTH  requester 1 signed integer
- in1_ready  output  1  requester 1 operand accepted this cycle
- out_valid  output  1  result available
- out_data  output  BUS_WIDTH  IEEE-754 result {sign, exponent, mantissa}
- out_id  output  1  requester that issued this result
- out_ready  input  1  consumer accepts result
- busy  output  1  S1 or S2 occupied

Behaviour:
- Reset (asynchronous): S1/S2 valid=0, S1/S2 data=0, out_data=0, out_id=0, out_valid=0, in*_ready=0, busy=0, rr_ptr=0 (requester 0 preferred).
- Handshake: a transfer occurs when valid && ready are both high at a rising edge. valid, once raised, holds with stable data until accepted. out_valid/out_data/out_id stay stable while out_ready=0.
- Pipeline advance:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - S2 loads S1's converted result when s1_valid && s2_adv.
  - S1 loads a granted operand when s1_adv.
  - A stage with nothing to load clears its valid when it advances.
- Arbitration (combinational grant, registered pointer):
  - Grant only when s1_adv=1.
  - One requester valid → it wins.
  - Both valid → requester rr_ptr wins.
  - in_k_ready = grant_k. At most one ready high per cycle.
  - On a grant to k, rr_ptr ← !k. No grant → rr_ptr unchanged.
- Latency and throughput:
  - Accept at edge N → out_valid at edge N+2 when unstalled.
  - Full throughput: 1 result/cycle with out_ready held high.
  - Both requesters continuously valid → grants strictly alternate.
- Conversion (combinational, between S1 and S2):
  - S = bit[BUS_WIDTH-1]; mag = S ? (~x+1) : x.
  - p = index of leading 1 of mag.
  - E = p + BIAS.
  - M = bits of mag below p, left-aligned into MANTISSA_SIZE; excess low bits truncated (round toward zero, no rounding).
  - x=0 → all-zero (+0.0).
  - Most-negative integer: mag wraps to itself and is treated as unsigned 2^(BUS_WIDTH-1) → -2^(BUS_WIDTH-1) exactly.
- Stall boundary: out_ready=0 with S2 full → S1 holds; next grant only if S1 is empty. Both stages full → no ready asserted.
- Simultaneous pop/push: S2 draining while S1 is full → S1 moves to S2 and S1 accepts a new operand in the same cycle.
- Reset mid-operation: in-flight operands are discarded; no partial result is emitted after reset release.

Optional Feature:
- Macro: FCVT_RR_INEXACT_EN.
- Defined:
  - Adds output port out_inexact (1 bit), piped alongside out_data.
  - out_inexact = 1 iff any nonzero bit of mag was truncated below the mantissa LSB.
  - Reset value 0.
- Undefined: port absent; no extra logic.

Test Plan:
- Reset then idle: all outputs 0, busy=0. Assert rst mid-stream with both stages full → out_valid drops immediately and nothing emerges after release.
- Single op: in0_data=5 (BUS_WIDTH=64) → 2 cycles later out_valid=1, out_data=0x4014000000000000, out_id=0. in1_data=-1 → 0xBFF0000000000000, out_id=1. Zero → 0x0.
- Contention: both valid for 6 cycles, out_ready=1 → grants 0,1,0,1,0,1 and outputs in the same order with matching out_id.
- Backpressure: out_ready=0 for 4 cycles with both requesters valid → exactly 2 operands accepted, then both readys low. Results are held stable, then drain in order once out_ready=1.
- Boundary values: 0x8000000000000000 → 0xC3E0000000000000. 0x0020000000000001 → 0x4340000000000000, with out_inexact=1 when FCVT_RR_INEXACT_EN is defined. BUS_WIDTH=32: 7 → 0x40E00000.
